// File: rtl/nn_pkg.sv
// nn_pkg: state encoding and default dimensions shared by the activation
// collector and its interface.
package nn_pkg;

  localparam int NN_WORD_W     = 16;
  localparam int NN_NEURON_MAX = 256;
  localparam int NN_CNT_W      = $clog2(NN_NEURON_MAX + 1);
  localparam int NN_ADDR_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/act_pack_if.sv
// act_pack_if: layer control, activation-bit input and word-write output of
// act_pack. The slave modport is the collector side; master is its environment.
interface act_pack_if
  import nn_pkg::*;
#(
  parameter int WORD_W = NN_WORD_W,
  parameter int CNT_W  = NN_CNT_W,
  parameter int ADDR_W = NN_ADDR_W
);

  logic              layer_start;
  logic [CNT_W-1:0]  layer_len;
  logic              act_valid;
  logic              act_bit;
  logic              act_ready;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              wr_last;
  logic              busy;
  logic              done;

  modport master (
    output layer_start, layer_len, act_valid, act_bit, wr_ready,
    input  act_ready, wr_valid, wr_addr, wr_data, wr_last, busy, done
  );

  modport slave (
    input  layer_start, layer_len, act_valid, act_bit, wr_ready,
    output act_ready, wr_valid, wr_addr, wr_data, wr_last, busy, done
  );

endinterface

// File: rtl/act_word_asm.sv
// act_word_asm: LSB-first word assembler -- a bit-index counter plus the word
// register it fills. Clear wins over load.
module act_word_asm
  import nn_pkg::*;
#(
  parameter int WORD_W = NN_WORD_W,
  parameter int IDX_W  = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_bit,
  input  logic              i_clear,
  output logic [WORD_W-1:0] o_word,
  output logic [IDX_W-1:0]  o_bit_idx
);

  logic [WORD_W-1:0] r_word;
  logic [IDX_W-1:0]  r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_word[r_idx] <= i_bit;
      r_idx         <= r_idx + IDX_W'(1);
    end
  end

  assign o_word    = r_word;
  assign o_bit_idx = r_idx;

endmodule

// File: rtl/act_pack.sv
// act_pack: collects one activation bit per neuron, packs them LSB-first into
// words and writes them out. Define ACT_PACK_POPCOUNT_EN to add pop_cnt.
module act_pack
  import nn_pkg::*;
#(
  parameter int WORD_W     = NN_WORD_W,
  parameter int NEURON_MAX = NN_NEURON_MAX,
  parameter int CNT_W      = NN_CNT_W,
  parameter int ADDR_W     = NN_ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  act_pack_if.slave        bus
`ifdef ACT_PACK_POPCOUNT_EN
  ,
  output logic [CNT_W-1:0] pop_cnt
`endif
);

  localparam int IDX_W = $clog2(WORD_W);

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_acc_cnt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [IDX_W-1:0]  w_bit_idx;
  logic [WORD_W-1:0] w_word;
  logic [CNT_W-1:0]  w_len_clamped;
  logic              w_start;
  logic              w_accept;
  logic              w_word_end;
  logic              w_wr_hs;
  logic              w_last;
  logic              w_clear;

  assign w_start       = (r_state == ST_IDLE) && bus.layer_start;
  assign w_accept      = (r_state == ST_COLLECT) && bus.act_valid;
  assign w_wr_hs       = (r_state == ST_WRITE) && bus.wr_ready;
  assign w_last        = (r_acc_cnt == r_len);
  assign w_word_end    = w_accept && ((w_bit_idx == IDX_W'(WORD_W - 1)) ||
                                      (r_acc_cnt + CNT_W'(1) == r_len));
  assign w_clear       = w_start || (w_wr_hs && !w_last);
  assign w_len_clamped = (bus.layer_len > CNT_W'(NEURON_MAX)) ? CNT_W'(NEURON_MAX)
                                                              : bus.layer_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Handshake/status outputs decode the state register only.
  always_comb begin
    w_state_next  = r_state;
    bus.act_ready = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        bus.busy = 1'b0;
        if (bus.layer_start)
          w_state_next = (bus.layer_len == '0) ? ST_DONE : ST_COLLECT;
      end
      ST_COLLECT: begin
        bus.act_ready = 1'b1;
        if (w_word_end) w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        bus.wr_valid = 1'b1;
        if (bus.wr_ready) w_state_next = w_last ? ST_DONE : ST_COLLECT;
      end
      ST_DONE: begin
        bus.done     = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len     <= '0;
      r_acc_cnt <= '0;
      r_wr_addr <= '0;
    end else if (w_start) begin
      r_len     <= w_len_clamped;
      r_acc_cnt <= '0;
      r_wr_addr <= '0;
    end else begin
      if (w_accept) r_acc_cnt <= r_acc_cnt + CNT_W'(1);
      if (w_wr_hs)  r_wr_addr <= r_wr_addr + ADDR_W'(1);
    end
  end

  act_word_asm #(
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_word_asm (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_accept),
    .i_bit     (bus.act_bit),
    .i_clear   (w_clear),
    .o_word    (w_word),
    .o_bit_idx (w_bit_idx)
  );

  assign bus.wr_data = w_word;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_last = (r_state == ST_WRITE) && w_last;

`ifdef ACT_PACK_POPCOUNT_EN
  logic [CNT_W-1:0] r_pop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           r_pop_cnt <= '0;
    else if (w_start)                  r_pop_cnt <= '0;
    else if (w_accept && bus.act_bit)  r_pop_cnt <= r_pop_cnt + CNT_W'(1);
  end

  assign pop_cnt = r_pop_cnt;
`endif

endmodule

// File: tb/tb_act_pack.sv
// tb_act_pack: directed bench for act_pack; expected words are queued when a
// layer is started and popped when the DUT completes a write handshake.
module tb_act_pack;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
    logic        last;
  } wr_exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cyc;
  int   start_cyc;
  int   done_cyc;
  int   done_count;
  int   wr_valid_cycles;
  wr_exp_t exp_q[$];
  wr_exp_t mon_e;

  act_pack_if #(.WORD_W(16), .CNT_W(9), .ADDR_W(8)) bus ();

`ifdef ACT_PACK_POPCOUNT_EN
  logic [8:0] pop_cnt;
`endif

  act_pack dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus)
`ifdef ACT_PACK_POPCOUNT_EN
    ,
    .pop_cnt (pop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor and scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_valid) wr_valid_cycles++;
      if (bus.done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (bus.wr_valid && bus.wr_ready) begin
        $display("wr addr=%0d data=%h last=%b", bus.wr_addr, bus.wr_data, bus.wr_last);
        check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(bus.wr_addr), 32'(mon_e.addr));
          check("wr_data", 32'(bus.wr_data), 32'(mon_e.data));
          check("wr_last", 32'(bus.wr_last), 32'(mon_e.last));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_layer(input int len, input logic [255:0] bits);
    int n;
    int nw;
    wr_exp_t e;
    n  = (len > 256) ? 256 : len;
    nw = (n + 15) / 16;
    for (int w = 0; w < nw; w++) begin
      e.addr = 8'(w);
      e.data = '0;
      for (int i = 0; i < 16; i++)
        if (w * 16 + i < n) e.data[i] = bits[w * 16 + i];
      e.last = (w == nw - 1);
      exp_q.push_back(e);
    end
  endtask

  function automatic int ones(input int len, input logic [255:0] bits);
    int c = 0;
    for (int i = 0; i < len && i < 256; i++) c += int'(bits[i]);
    return c;
  endfunction

  task automatic start_layer(input int len);
    bus.layer_start = 1'b1;
    bus.layer_len   = 9'(len);
    start_cyc       = cyc;
    $display("layer_start len=%0d", len);
    tick();
    bus.layer_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    int guard;
    guard         = 0;
    bus.act_valid = 1'b1;
    bus.act_bit   = b;
    while (!bus.act_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check("act_ready_wait", 32'(bus.act_ready), 32'd1);
    tick();
    bus.act_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int guard;
    guard = 0;
    while (done_count < target && guard < 400) begin
      tick();
      guard++;
    end
    check("done_count", 32'(done_count), 32'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_act_ready"}, 32'(bus.act_ready), 32'd0);
    check({tag, "_wr_valid"},  32'(bus.wr_valid),  32'd0);
    check({tag, "_wr_addr"},   32'(bus.wr_addr),   32'd0);
    check({tag, "_wr_data"},   32'(bus.wr_data),   32'd0);
    check({tag, "_wr_last"},   32'(bus.wr_last),   32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_done"},      32'(bus.done),      32'd0);
  endtask

  initial begin
    logic [255:0] pat;
    logic [15:0]  exp_word;
    int           done_exp;

    n_checks = 0; n_fail = 0; cyc = 0; done_count = 0; wr_valid_cycles = 0;
    done_exp = 0; start_cyc = 0; done_cyc = 0;
    rst = 1'b1;
    bus.layer_start = 1'b0; bus.layer_len = '0;
    bus.act_valid = 1'b0; bus.act_bit = 1'b0; bus.wr_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    check_reset_outputs("reset");
`ifdef ACT_PACK_POPCOUNT_EN
    check("reset_pop_cnt", 32'(pop_cnt), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // 16 alternating bits starting with 1 -> 16'h5555, done 18 cycles after start cycle
    pat = '0;
    for (int i = 0; i < 16; i++) pat[i] = (i % 2 == 0);
    expect_layer(16, pat);
    start_layer(16);
    check("collect_entered", 32'(bus.act_ready), 32'd1);
    for (int i = 0; i < 16; i++) send_bit(pat[i]);
    done_exp++;
    wait_done(done_exp);
    check("latency16", 32'(done_cyc - start_cyc), 32'd18);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // 20 ones -> FFFF then 000F
    pat = '1;
    expect_layer(20, pat);
    start_layer(20);
    for (int i = 0; i < 20; i++) send_bit(pat[i]);
    done_exp++;
    wait_done(done_exp);
`ifdef ACT_PACK_POPCOUNT_EN
    check("pop_cnt20", 32'(pop_cnt), 32'd20);
`endif

    // wr_ready stall for 5 cycles in WRITE
    pat = {8{$urandom()}};
    exp_word = pat[15:0];
    expect_layer(16, pat);
    bus.wr_ready = 1'b0;
    start_layer(16);
    for (int i = 0; i < 16; i++) send_bit(pat[i]);
    bus.act_valid = 1'b1;
    bus.act_bit   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("stall_wr_valid",  32'(bus.wr_valid),  32'd1);
      check("stall_wr_data",   32'(bus.wr_data),   32'(exp_word));
      check("stall_wr_addr",   32'(bus.wr_addr),   32'd0);
      check("stall_act_ready", 32'(bus.act_ready), 32'd0);
      tick();
    end
    bus.wr_ready = 1'b1;
    tick();
    check("stall_done", 32'(bus.done), 32'd1);
    bus.act_valid = 1'b0;
    done_exp++;
    wait_done(done_exp);
`ifdef ACT_PACK_POPCOUNT_EN
    check("pop_cnt_stall", 32'(pop_cnt), 32'(ones(16, pat)));
`endif

    // Zero-length layer
    wr_valid_cycles = 0;
    start_layer(0);
    done_exp++;
    wait_done(done_exp);
    check("latency0", 32'(done_cyc - start_cyc), 32'd1);
    check("len0_no_write", 32'(wr_valid_cycles), 32'd0);

    // Reset after 7 of 16 bits, then a 4-bit layer 1,1,0,1 -> 16'h000B
    pat = '1;
    start_layer(16);
    for (int i = 0; i < 7; i++) send_bit(pat[i]);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick();
    tick();
    rst = 1'b0;
    check("midrst_no_done", 32'(done_count), 32'(done_exp));
    tick();
    pat = '0;
    pat[3:0] = 4'b1011;
    expect_layer(4, pat);
    start_layer(4);
    for (int i = 0; i < 4; i++) send_bit(pat[i]);
    done_exp++;
    wait_done(done_exp);

    // layer_start during COLLECT with a different length is ignored
    pat = {8{$urandom()}};
    expect_layer(20, pat);
    start_layer(20);
    for (int i = 0; i < 5; i++) send_bit(pat[i]);
    bus.layer_start = 1'b1;
    bus.layer_len   = 9'd3;
    send_bit(pat[5]);
    bus.layer_start = 1'b0;
    for (int i = 6; i < 20; i++) send_bit(pat[i]);
    done_exp++;
    wait_done(done_exp);

    // Oversized layer_len is clamped to 256 neurons (16 words)
    pat = {8{$urandom()}};
    expect_layer(300, pat);
    start_layer(300);
    for (int i = 0; i < 256; i++) send_bit(pat[i]);
    done_exp++;
    wait_done(done_exp);
`ifdef ACT_PACK_POPCOUNT_EN
    check("pop_cnt_clamp", 32'(pop_cnt), 32'(ones(256, pat)));
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
